// File: rtl/state_dump_unit.sv
// Debug dump responder: walks the register file, then a window of data memory,
// and streams each word out over a valid/ready port with a one-deep output register.
module state_dump_unit #(
  parameter int NUM_REGS  = 32,
  parameter int MEM_AW    = 10,
  parameter int MEM_BASE  = 0,
  parameter int MEM_WORDS = 16,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [MEM_AW-1:0] dm_raddr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic [MEM_AW-1:0] out_index,
  output logic [DATA_W-1:0] out_data
);

  // Walk index must count to whichever of the two phases is longer.
  localparam int IDX_W = ((MEM_AW > 5) ? MEM_AW : 5) + 1;
  localparam logic [IDX_W-1:0]  LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0]  LAST_MEM = IDX_W'((MEM_WORDS == 0) ? 0 : MEM_WORDS - 1);
  localparam logic [MEM_AW-1:0] BASE     = MEM_AW'(MEM_BASE);

  typedef enum logic [1:0] {S_IDLE, S_REG, S_MEM, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                src_q, src_d;
  logic [MEM_AW-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                load;
  logic [MEM_AW-1:0]   mem_addr;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    src_d    = src_q;
    index_d  = index_q;
    data_d   = data_q;
    done_d   = 1'b0;
    rf_raddr = '0;
    dm_raddr = '0;
    mem_addr = BASE + idx_q[MEM_AW-1:0];
    load     = ((state_q == S_REG) || (state_q == S_MEM)) && (!valid_q || out_ready);

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          state_d = S_REG;
          idx_d   = '0;
        end
      end
      S_REG: begin
        rf_raddr = idx_q[4:0];
        if (load) begin
          data_d  = rf_rdata;
          src_d   = 1'b0;
          index_d = MEM_AW'(idx_q);
          valid_d = 1'b1;
          if (idx_q == LAST_REG) begin
            idx_d   = '0;
            state_d = (MEM_WORDS == 0) ? S_DRAIN : S_MEM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_MEM: begin
        // Window may run past the top of memory; the address wraps silently.
        dm_raddr = mem_addr;
        if (load) begin
          data_d  = dm_rdata;
          src_d   = 1'b1;
          index_d = mem_addr;
          valid_d = 1'b1;
          if (idx_q == LAST_MEM) state_d = S_DRAIN;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (valid_q && out_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      index_q <= index_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_src   = src_q;
  assign out_index = index_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: three instances (default window, wrapping window,
// no memory phase) checked against a list-based model of the expected dump.
module tb_state_dump_unit;
  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct packed {
    logic          src;
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dump_req = 1'b0;
  logic out_ready = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] rf  [32];
  logic [DW-1:0] mem [1024];

  logic          busy [3], done [3], out_valid [3], out_src [3];
  logic [4:0]    rf_raddr [3];
  logic [AW-1:0] dm_raddr [3], out_index [3];
  logic [DW-1:0] rf_rdata [3], dm_rdata [3], out_data [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rf_rdata[i] = rf[rf_raddr[i]];
      dm_rdata[i] = mem[dm_raddr[i]];
    end
  end

  state_dump_unit u0 (
    .clk(clk), .rst(rst), .dump_req(dump_req), .busy(busy[0]), .done(done[0]),
    .rf_raddr(rf_raddr[0]), .rf_rdata(rf_rdata[0]), .dm_raddr(dm_raddr[0]), .dm_rdata(dm_rdata[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_src(out_src[0]),
    .out_index(out_index[0]), .out_data(out_data[0]));

  state_dump_unit #(.MEM_BASE(1020), .MEM_WORDS(8)) u1 (
    .clk(clk), .rst(rst), .dump_req(dump_req), .busy(busy[1]), .done(done[1]),
    .rf_raddr(rf_raddr[1]), .rf_rdata(rf_rdata[1]), .dm_raddr(dm_raddr[1]), .dm_rdata(dm_rdata[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_src(out_src[1]),
    .out_index(out_index[1]), .out_data(out_data[1]));

  state_dump_unit #(.MEM_WORDS(0)) u2 (
    .clk(clk), .rst(rst), .dump_req(dump_req), .busy(busy[2]), .done(done[2]),
    .rf_raddr(rf_raddr[2]), .rf_rdata(rf_rdata[2]), .dm_raddr(dm_raddr[2]), .dm_rdata(dm_rdata[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_src(out_src[2]),
    .out_index(out_index[2]), .out_data(out_data[2]));

  int cfg_base  [3] = '{0, 1020, 0};
  int cfg_words [3] = '{16, 8, 0};

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  beat_t q0 [$], q1 [$], q2 [$], got_q [$], exp_q [$];
  int done_cnt [3], done_cyc [3], first_cyc [3], stab_err [3];
  int dm_nz;
  logic  pv [3];
  beat_t pb [3];
  logic [4:0]    pra [3];
  logic [AW-1:0] pda [3];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: accepted beats, done pulses, and stall stability, sampled mid-cycle.
  initial begin
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        beat_t b;
        b = {out_src[i], out_index[i], out_data[i]};
        if (rst && out_valid[i] && out_ready) begin
          if (i == 0) q0.push_back(b);
          else if (i == 1) q1.push_back(b);
          else q2.push_back(b);
        end
        if (done[i] === 1'b1) begin
          done_cnt[i]++;
          if (done_cyc[i] < 0) done_cyc[i] = cyc;
        end
        if (out_valid[i] === 1'b1 && first_cyc[i] < 0) first_cyc[i] = cyc;
        if (pv[i] && (out_valid[i] !== 1'b1 || b !== pb[i] ||
                      rf_raddr[i] !== pra[i] || dm_raddr[i] !== pda[i])) stab_err[i]++;
        pv[i]  = rst && out_valid[i] && !out_ready;
        pb[i]  = b;
        pra[i] = rf_raddr[i];
        pda[i] = dm_raddr[i];
      end
      if (dm_raddr[2] !== '0) dm_nz++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0; done_cyc[i] = -1; first_cyc[i] = -1; stab_err[i] = 0;
    end
    dm_nz = 0;
  endtask

  task automatic randomize_state();
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    for (int a = 0; a < 1024; a++) mem[a] = $urandom;
  endtask

  task automatic start_dump(output int n0);
    dump_req = 1'b1;
    n0 = cyc;
    tick();
    dump_req = 1'b0;
  endtask

  // Reference: registers ascending, then the memory window ascending with wrap.
  task automatic build_exp(input int i);
    int a;
    exp_q.delete();
    for (int r = 0; r < 32; r++) exp_q.push_back(beat_t'({1'b0, AW'(r), rf[r]}));
    for (int m = 0; m < cfg_words[i]; m++) begin
      a = (cfg_base[i] + m) % 1024;
      exp_q.push_back(beat_t'({1'b1, AW'(a), mem[a]}));
    end
  endtask

  task automatic get_q(input int i);
    if (i == 0) got_q = q0;
    else if (i == 1) got_q = q1;
    else got_q = q2;
  endtask

  // mode 0: ready held high, 1: pattern 1,0,0 repeating, 2: random
  task automatic wait_idle(input int mode);
    int t = 0;
    do begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (t % 3 == 0);
        default: out_ready = 1'($urandom % 2);
      endcase
      @(negedge clk);
      t++;
    end while ((busy[0] || busy[1] || busy[2]) && t < 2000);
    n_chk++;
    if (t >= 2000) begin n_fail++; $display("FAIL wait_idle timeout: busy still %0b%0b%0b after %0d cycles", busy[0], busy[1], busy[2], t); end
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; dump_req = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (busy[i] !== 1'b0)      begin n_fail++; $display("FAIL reset busy[%0d]: got %b want 0", i, busy[i]); end
      n_chk++; if (done[i] !== 1'b0)      begin n_fail++; $display("FAIL reset done[%0d]: got %b want 0", i, done[i]); end
      n_chk++; if (out_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset out_valid[%0d]: got %b want 0", i, out_valid[i]); end
      n_chk++; if (out_src[i] !== 1'b0)   begin n_fail++; $display("FAIL reset out_src[%0d]: got %b want 0", i, out_src[i]); end
      n_chk++; if (out_index[i] !== '0)   begin n_fail++; $display("FAIL reset out_index[%0d]: got %0d want 0", i, out_index[i]); end
      n_chk++; if (out_data[i] !== '0)    begin n_fail++; $display("FAIL reset out_data[%0d]: got %h want 0", i, out_data[i]); end
      n_chk++; if (rf_raddr[i] !== '0)    begin n_fail++; $display("FAIL reset rf_raddr[%0d]: got %0d want 0", i, rf_raddr[i]); end
      n_chk++; if (dm_raddr[i] !== '0)    begin n_fail++; $display("FAIL reset dm_raddr[%0d]: got %0d want 0", i, dm_raddr[i]); end
    end
    tick();
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int n0;
    beat_t b1, b44;
    randomize_state();
    rf[1] = 5; rf[2] = 10; rf[10] = 15; mem[12] = 42;
    clear_mon();
    start_dump(n0);
    wait_idle(0);
    for (int i = 0; i < 3; i++) begin
      get_q(i); build_exp(i);
      n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic count[%0d]: got %0d want %0d", i, got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        n_chk++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL basic beat[%0d][%0d]: got %h want %h", i, k, got_q[k], exp_q[k]); end
      end
      n_chk++; if (done_cnt[i] != 1) begin n_fail++; $display("FAIL basic done_cnt[%0d]: got %0d want 1", i, done_cnt[i]); end
    end
    b1  = (q0.size() > 1)  ? q0[1]  : '0;
    b44 = (q0.size() > 44) ? q0[44] : '0;
    n_chk++; if (b1 !== beat_t'({1'b0, 10'd1, 32'd5}))    begin n_fail++; $display("FAIL basic beat1: got %h want src0 idx1 data5", b1); end
    n_chk++; if (b44 !== beat_t'({1'b1, 10'd12, 32'd42})) begin n_fail++; $display("FAIL basic beat44: got %h want src1 idx12 data42", b44); end
    n_chk++; if (first_cyc[0] != n0 + 2)  begin n_fail++; $display("FAIL basic first_beat_cycle: got %0d want %0d", first_cyc[0], n0 + 2); end
    n_chk++; if (done_cyc[0] != n0 + 50)  begin n_fail++; $display("FAIL basic done_cycle[0]: got %0d want %0d", done_cyc[0], n0 + 50); end
    n_chk++; if (done_cyc[1] != n0 + 42)  begin n_fail++; $display("FAIL basic done_cycle[1]: got %0d want %0d", done_cyc[1], n0 + 42); end
    n_chk++; if (done_cyc[2] != n0 + 34)  begin n_fail++; $display("FAIL basic done_cycle[2]: got %0d want %0d", done_cyc[2], n0 + 34); end
    n_chk++; if (dm_nz != 0) begin n_fail++; $display("FAIL basic dm_raddr_zero_phase: got %0d nonzero cycles want 0", dm_nz); end
  endtask

  task automatic test_stall(input int mode);
    int n0;
    randomize_state();
    clear_mon();
    start_dump(n0);
    wait_idle(mode);
    for (int i = 0; i < 3; i++) begin
      get_q(i); build_exp(i);
      n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall%0d count[%0d]: got %0d want %0d", mode, i, got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        n_chk++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL stall%0d beat[%0d][%0d]: got %h want %h", mode, i, k, got_q[k], exp_q[k]); end
      end
      n_chk++; if (stab_err[i] != 0) begin n_fail++; $display("FAIL stall%0d stability[%0d]: got %0d changes want 0", mode, i, stab_err[i]); end
      n_chk++; if (done_cnt[i] != 1) begin n_fail++; $display("FAIL stall%0d done_cnt[%0d]: got %0d want 1", mode, i, done_cnt[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    randomize_state();
    clear_mon();
    start_dump(n0);
    while (cyc < n0 + 21) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (out_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_mid out_valid[%0d]: got %b want 0", i, out_valid[i]); end
      n_chk++; if (busy[i] !== 1'b0)      begin n_fail++; $display("FAIL reset_mid busy[%0d]: got %b want 0", i, busy[i]); end
    end
    repeat (60) tick();
    for (int i = 0; i < 3; i++) begin
      get_q(i); build_exp(i);
      n_chk++; if (done_cnt[i] != 0)     begin n_fail++; $display("FAIL reset_mid done_cnt[%0d]: got %0d want 0", i, done_cnt[i]); end
      n_chk++; if (got_q.size() != 19)   begin n_fail++; $display("FAIL reset_mid partial_count[%0d]: got %0d want 19", i, got_q.size()); end
      for (int k = 0; k < 19 && k < got_q.size(); k++) begin
        n_chk++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL reset_mid beat[%0d][%0d]: got %h want %h", i, k, got_q[k], exp_q[k]); end
      end
    end
    clear_mon();
    start_dump(n0);
    wait_idle(0);
    for (int i = 0; i < 3; i++) begin
      get_q(i); build_exp(i);
      n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL restart count[%0d]: got %0d want %0d", i, got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        n_chk++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL restart beat[%0d][%0d]: got %h want %h", i, k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_busy_req();
    int n0;
    randomize_state();
    clear_mon();
    start_dump(n0);
    while (cyc < n0 + 11) tick();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_idle(0);
    for (int i = 0; i < 3; i++) begin
      get_q(i); build_exp(i);
      n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_req count[%0d]: got %0d want %0d", i, got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        n_chk++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL busy_req beat[%0d][%0d]: got %h want %h", i, k, got_q[k], exp_q[k]); end
      end
      n_chk++; if (done_cnt[i] != 1) begin n_fail++; $display("FAIL busy_req done_cnt[%0d]: got %0d want 1", i, done_cnt[i]); end
    end
    n_chk++; if (done_cyc[0] != n0 + 50) begin n_fail++; $display("FAIL busy_req done_cycle: got %0d want %0d", done_cyc[0], n0 + 50); end
  endtask

  task automatic test_back_to_back();
    int n0;
    randomize_state();
    clear_mon();
    start_dump(n0);
    while (cyc < n0 + 50) tick();
    @(negedge clk);
    n_chk++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b done_cycle: got done=%b busy=%b want done=1 busy=0", done[0], busy[0]); end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    @(negedge clk);
    n_chk++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL b2b restart_busy: got %b want 1", busy[0]); end
    wait_idle(0);
    get_q(0); build_exp(0);
    n_chk++; if (got_q.size() != 96) begin n_fail++; $display("FAIL b2b count: got %0d want 96", got_q.size()); end
    for (int k = 0; k < 96 && k < got_q.size(); k++) begin
      n_chk++; if (got_q[k] !== exp_q[k % 48]) begin n_fail++; $display("FAIL b2b beat[%0d]: got %h want %h", k, got_q[k], exp_q[k % 48]); end
    end
    n_chk++; if (done_cnt[0] != 2) begin n_fail++; $display("FAIL b2b done_cnt: got %0d want 2", done_cnt[0]); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_stall(1);
    test_stall(2);
    test_stall(2);
    test_reset_mid();
    test_busy_req();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/state_dump_unit.md
# state_dump_unit

Debug responder that walks the architectural register file and a window of data memory and streams each word out over a valid/ready handshake. It sits beside the register file and data memory in the processor top level. When a host or self-checking bench requests a dump, it produces a deterministic snapshot, so results are checked through a port instead of by probing hierarchical paths. It only reads through dedicated read ports and never disturbs pipeline state.

## Interface
- NUM_REGS, 32, register-file entries dumped (indices 0..NUM_REGS-1)
- MEM_AW, 10, data-memory word-index width
- MEM_BASE, 0, first data-memory word index dumped
- MEM_WORDS, 16, data-memory words dumped (0 = skip memory phase)
- DATA_W, 32, data width

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- dump_req  in  1  start request, sampled in IDLE only
- busy  out  1  high while a dump is in progress
- done  out  1  one-cycle pulse after final beat accepted
- rf_raddr  out  5  register-file read index (combinational read)
- rf_rdata  in  DATA_W  register-file read data, same cycle
- dm_raddr  out  MEM_AW  data-memory word index (combinational read)
- dm_rdata  in  DATA_W  data-memory read data, same cycle
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_src  out  1  0 = register, 1 = memory
- out_index  out  MEM_AW  register number, or memory word index (MEM_BASE+offset)
- out_data  out  DATA_W  captured word

## Operation
- FSM states: IDLE, REG, MEM, DRAIN.
- IDLE → REG when dump_req=1. Clear the walk index to 0. Otherwise hold.
- Load condition: load = (state is REG or MEM) && (!out_valid || out_ready).
- REG state:
  - rf_raddr = idx.
  - On load, capture rf_rdata, src=0, index=idx into the output registers and set out_valid=1.
  - If idx==NUM_REGS-1: go to MEM with idx=0, or to DRAIN if MEM_WORDS==0. Otherwise idx++.
- MEM state:
  - dm_raddr = (MEM_BASE+idx) mod 2^MEM_AW. Wrap is silent.
  - On load, capture dm_rdata, src=1, index=dm_raddr.
  - If idx==MEM_WORDS-1, go to DRAIN. Otherwise idx++.
- DRAIN: when out_valid && out_ready, clear out_valid, pulse done, and go to IDLE.
- If out_valid && out_ready and no load occurs, clear out_valid.
- Output registers (src, index, data) are stable while out_valid=1 and out_ready=0.
- dump_req while busy is ignored; it is not queued.
- busy = (state != IDLE).
- rf_raddr and dm_raddr read 0 when not in their respective phase.
- Register 0 is dumped as read; no forcing.
- Total beats per dump = NUM_REGS + MEM_WORDS, in strict order: registers ascending, then memory ascending.

## Timing
- Reset (rst=0 at a rising edge) forces:
  - state=IDLE, idx=0, busy=0, done=0, out_valid=0
  - out_src=0, out_index=0, out_data=0, rf_raddr=0, dm_raddr=0
- Reset mid-dump aborts immediately. out_valid falls at that edge. No done pulse.
- dump_req high at edge of cycle N: busy=1 in N+1, first beat valid in N+2.
- With out_ready held 1, beats stream one per cycle with no bubbles, including across the REG→MEM boundary.
- With defaults, beats occupy N+2..N+49. done=1 and busy=0 in N+50.
- out_ready low stalls the walk, and no read index advances. Resuming costs no extra cycle.
- done is high exactly one cycle, coincident with the first IDLE cycle.
- dump_req in that same cycle starts a new dump.

## Test plan
- Basic dump: preload x1=5, x2=10, x10=15, mem[12]=42; dump_req pulse, out_ready=1 → 48 beats in order.
  - Beat 1: src=0, index=1, data=5.
  - Beat 44: src=1, index=12, data=42.
  - done at N+50.
- Backpressure: toggle out_ready 1,0,0,1,… → every beat is held stable while stalled; no beat lost or duplicated; beat count is 48.
- Reset mid-dump: assert rst=0 during beat 20 → next cycle out_valid=0, busy=0, done never pulses. A subsequent dump_req restarts at register 0.
- Request while busy: second dump_req pulse at beat 10 → ignored; exactly 48 beats and one done.
- Wrap: MEM_BASE=1020, MEM_WORDS=8 → memory beats carry indices 1020, 1021, 1022, 1023, 0, 1, 2, 3 with matching data.
- MEM_WORDS=0 → exactly 32 register beats, then done; dm_raddr stays 0 throughout.
